// File: rtl/mold_pkg.sv
// rtl/mold_pkg.sv - shared MoldUDP64 retransmission types, widths and helpers
// Contents:
//   MOLD_SEQ_NUM_W / MOLD_SID_W / MOLD_ML_W  default field widths
//   miss_req_t      one queued gap {sid, start, cnt}
//   sched_state_e   scheduler FSM states
//   clip_cnt()      min(remaining, max per request) narrowed to a request count
package mold_pkg;

    localparam int MOLD_SEQ_NUM_W = 64;
    localparam int MOLD_SID_W     = 80;
    localparam int MOLD_ML_W      = 16;

    typedef struct packed {
        logic [MOLD_SID_W-1:0]     sid;
        logic [MOLD_SEQ_NUM_W-1:0] start;
        logic [MOLD_SEQ_NUM_W-1:0] cnt;
    } miss_req_t;

    typedef enum logic [1:0] {
        SCHED_IDLE,
        SCHED_LOAD,
        SCHED_SEND,
        SCHED_WAIT
    } sched_state_e;

    function automatic logic [MOLD_ML_W-1:0] clip_cnt(
        input logic [MOLD_SEQ_NUM_W-1:0] rem,
        input logic [MOLD_ML_W-1:0]      max_cnt
    );
        logic [MOLD_SEQ_NUM_W-1:0] max_ext;
        max_ext = {{(MOLD_SEQ_NUM_W-MOLD_ML_W){1'b0}}, max_cnt};
        return (rem > max_ext) ? max_cnt : rem[MOLD_ML_W-1:0];
    endfunction

endpackage

// File: rtl/miss_req_sched_if.sv
// rtl/miss_req_sched_if.sv - retransmission request channel (valid/ready)
// Signals:
//   req_v_o        request valid (scheduler -> sink)
//   req_ready_i    sink ready    (sink -> scheduler)
//   req_sid_o      request session id
//   req_seq_num_o  first requested sequence number
//   req_msg_cnt_o  number of messages requested
// Modports: master (scheduler side), slave (request sink side)
interface miss_req_sched_if #(
    parameter int SEQ_NUM_W = 64,
    parameter int SID_W     = 80,
    parameter int ML_W      = 16
);
    logic                 req_v_o;
    logic                 req_ready_i;
    logic [SID_W-1:0]     req_sid_o;
    logic [SEQ_NUM_W-1:0] req_seq_num_o;
    logic [ML_W-1:0]      req_msg_cnt_o;

    modport master (
        output req_v_o, req_sid_o, req_seq_num_o, req_msg_cnt_o,
        input  req_ready_i
    );

    modport slave (
        input  req_v_o, req_sid_o, req_seq_num_o, req_msg_cnt_o,
        output req_ready_i
    );
endinterface

// File: rtl/miss_req_fifo.sv
// rtl/miss_req_fifo.sv - synchronous FIFO of pending gap entries
// Ports:
//   clk, rst_n   clock, async active-low reset (pointers/count only)
//   push, push_data   write request; accepted when not full or when popping same cycle
//   pop, pop_data     read request; pop_data is the current head (show-ahead)
//   full, empty       occupancy flags
module miss_req_fifo
    import mold_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic      clk,
    input  logic      rst_n,
    input  logic      push,
    input  miss_req_t push_data,
    input  logic      pop,
    output miss_req_t pop_data,
    output logic      full,
    output logic      empty
);
    localparam int AW = $clog2(DEPTH);

    miss_req_t       mem [DEPTH];
    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [AW:0]     count;
    logic            do_push;
    logic            do_pop;

    assign full     = (count == (AW+1)'(DEPTH));
    assign empty    = (count == '0);
    assign do_pop   = pop && !empty;
    // A full FIFO still takes a write when the head leaves in the same cycle.
    assign do_push  = push && (!full || do_pop);
    assign pop_data = mem[rd_ptr];

    // Storage carries no reset; only pointers define validity.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= push_data;
        end
    end

    // DEPTH is a power of two, so pointers wrap naturally.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end
endmodule

// File: rtl/miss_req_sched.sv
// rtl/miss_req_sched.sv - retransmission request scheduler with chunking, timeout and retry
// Queues sequence-gap events, splits each gap into request-sized chunks, issues them one at a
// time and waits for the matching retransmitted fill; times out, retries, finally drops.
// Ports:
//   clk, nreset                         clock, async active-low reset
//   miss_seq_num_v_i/_sid_i/_start_i/_cnt_i   gap event input
//   fill_v_i/_sid_i/_seq_num_i/_msg_cnt_i     retransmitted packet observed
//   rq (miss_req_sched_if.master)       request channel
//   overflow_o                          pulse: gap event lost, queue full
//   drop_o                              pulse: chunk abandoned after RETRY_MAX retries
//   stat_req_o/stat_retry_o/stat_drop_o/stat_ovf_o   32b saturating counters,
//                                       present only with MISS_REQ_SCHED_STATS_EN defined
module miss_req_sched
    import mold_pkg::*;
#(
    parameter int          SEQ_NUM_W   = MOLD_SEQ_NUM_W,
    parameter int          SID_W       = MOLD_SID_W,
    parameter int          ML_W        = MOLD_ML_W,
    parameter int          FIFO_DEPTH  = 4,
    parameter int unsigned MAX_REQ_CNT = 16'hFFFF,
    parameter int          TIMEOUT     = 1024,
    parameter int          RETRY_MAX   = 3
) (
    input  logic                 clk,
    input  logic                 nreset,
    input  logic                 miss_seq_num_v_i,
    input  logic [SID_W-1:0]     miss_seq_num_sid_i,
    input  logic [SEQ_NUM_W-1:0] miss_seq_num_start_i,
    input  logic [SEQ_NUM_W-1:0] miss_seq_num_cnt_i,
    input  logic                 fill_v_i,
    input  logic [SID_W-1:0]     fill_sid_i,
    input  logic [SEQ_NUM_W-1:0] fill_seq_num_i,
    input  logic [ML_W-1:0]      fill_msg_cnt_i,
    miss_req_sched_if.master     rq,
    output logic                 overflow_o,
`ifdef MISS_REQ_SCHED_STATS_EN
    output logic                 drop_o,
    output logic [31:0]          stat_req_o,
    output logic [31:0]          stat_retry_o,
    output logic [31:0]          stat_drop_o,
    output logic [31:0]          stat_ovf_o
`else
    output logic                 drop_o
`endif
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam int RW = $clog2(RETRY_MAX + 2);
    localparam logic [ML_W-1:0] MAX_CNT = ML_W'(MAX_REQ_CNT);

    sched_state_e         state_q;
    logic [SID_W-1:0]     cur_sid_q;
    logic [SEQ_NUM_W-1:0] cur_start_q;
    logic [SEQ_NUM_W-1:0] cur_rem_q;
    logic [ML_W-1:0]      req_cnt_q;
    logic                 req_v_q;
    logic [TW-1:0]        timer_q;
    logic [RW-1:0]        retry_q;
    logic                 overflow_q;
    logic                 drop_q;

    miss_req_t            head;
    miss_req_t            ev_data;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 ev_valid;
    logic                 push;
    logic                 pop;
    logic                 ovf;

    logic                 hit;
    logic                 timeout;
    logic                 can_retry;
    logic [ML_W-1:0]      cov;
    logic [ML_W-1:0]      adv;
    logic [SEQ_NUM_W-1:0] nxt_start;
    logic [SEQ_NUM_W-1:0] nxt_rem;

    // ---------------- gap queue ----------------
    assign ev_valid = miss_seq_num_v_i && (miss_seq_num_cnt_i != '0);
    assign pop      = (state_q == SCHED_LOAD);
    assign push     = ev_valid && (!fifo_full || pop);
    assign ovf      = ev_valid && fifo_full && !pop;
    assign ev_data  = '{sid: miss_seq_num_sid_i, start: miss_seq_num_start_i,
                        cnt: miss_seq_num_cnt_i};

    miss_req_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (nreset),
        .push      (push),
        .push_data (ev_data),
        .pop       (pop),
        .pop_data  (head),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // ---------------- chunk progress ----------------
    assign hit       = fill_v_i && (fill_sid_i == cur_sid_q) && (fill_seq_num_i == cur_start_q);
    assign timeout   = (timer_q == TW'(TIMEOUT - 1));
    assign can_retry = (retry_q < RW'(RETRY_MAX));
    // A fill may cover less than was asked for; never credit more than the request.
    assign cov       = (fill_msg_cnt_i < req_cnt_q) ? fill_msg_cnt_i : req_cnt_q;
    // On a hit advance by what arrived; on a drop skip the whole chunk.
    assign adv       = hit ? cov : req_cnt_q;
    assign nxt_start = cur_start_q + SEQ_NUM_W'(adv);
    assign nxt_rem   = cur_rem_q - SEQ_NUM_W'(adv);

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            state_q     <= SCHED_IDLE;
            cur_sid_q   <= '0;
            cur_start_q <= '0;
            cur_rem_q   <= '0;
            req_cnt_q   <= '0;
            req_v_q     <= 1'b0;
            timer_q     <= '0;
            retry_q     <= '0;
            overflow_q  <= 1'b0;
            drop_q      <= 1'b0;
        end else begin
            overflow_q <= ovf;
            drop_q     <= 1'b0;
            case (state_q)
                SCHED_IDLE: begin
                    if (!fifo_empty) state_q <= SCHED_LOAD;
                end
                SCHED_LOAD: begin
                    cur_sid_q   <= head.sid;
                    cur_start_q <= head.start;
                    cur_rem_q   <= head.cnt;
                    req_cnt_q   <= clip_cnt(head.cnt, MAX_CNT);
                    retry_q     <= '0;
                    req_v_q     <= 1'b1;
                    state_q     <= SCHED_SEND;
                end
                SCHED_SEND: begin
                    if (rq.req_ready_i) begin
                        req_v_q <= 1'b0;
                        timer_q <= '0;
                        state_q <= SCHED_WAIT;
                    end
                end
                SCHED_WAIT: begin
                    if (hit || (timeout && !can_retry)) begin
                        // Hit has priority over a coincident timeout.
                        cur_start_q <= nxt_start;
                        cur_rem_q   <= nxt_rem;
                        retry_q     <= '0;
                        drop_q      <= !hit;
                        if (nxt_rem == '0) begin
                            state_q <= SCHED_IDLE;
                        end else begin
                            req_cnt_q <= clip_cnt(nxt_rem, MAX_CNT);
                            req_v_q   <= 1'b1;
                            state_q   <= SCHED_SEND;
                        end
                    end else if (timeout) begin
                        retry_q <= retry_q + 1'b1;
                        req_v_q <= 1'b1;
                        state_q <= SCHED_SEND;
                    end else begin
                        timer_q <= timer_q + 1'b1;
                    end
                end
                default: state_q <= SCHED_IDLE;
            endcase
        end
    end

    assign rq.req_v_o       = req_v_q;
    assign rq.req_sid_o     = cur_sid_q;
    assign rq.req_seq_num_o = cur_start_q;
    assign rq.req_msg_cnt_o = req_cnt_q;
    assign overflow_o       = overflow_q;
    assign drop_o           = drop_q;

`ifdef MISS_REQ_SCHED_STATS_EN
    logic ev_req;
    logic ev_retry;
    logic ev_drop;

    assign ev_req   = (state_q == SCHED_SEND) && rq.req_ready_i;
    assign ev_retry = (state_q == SCHED_WAIT) && !hit && timeout && can_retry;
    assign ev_drop  = (state_q == SCHED_WAIT) && !hit && timeout && !can_retry;

    always_ff @(posedge clk or negedge nreset) begin
        if (!nreset) begin
            stat_req_o   <= '0;
            stat_retry_o <= '0;
            stat_drop_o  <= '0;
            stat_ovf_o   <= '0;
        end else begin
            if (ev_req   && (stat_req_o   != '1)) stat_req_o   <= stat_req_o + 1'b1;
            if (ev_retry && (stat_retry_o != '1)) stat_retry_o <= stat_retry_o + 1'b1;
            if (ev_drop  && (stat_drop_o  != '1)) stat_drop_o  <= stat_drop_o + 1'b1;
            if (ovf      && (stat_ovf_o   != '1)) stat_ovf_o   <= stat_ovf_o + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_miss_req_sched.sv
// tb/tb_miss_req_sched.sv - directed self-checking bench for miss_req_sched
module tb_miss_req_sched;
    localparam int TIMEOUT   = 64;
    localparam int RETRY_MAX = 3;
    localparam int DEPTH     = 4;

    logic        clk = 1'b0;
    logic        nreset = 1'b0;
    logic        miss_v = 1'b0;
    logic [79:0] miss_sid = '0;
    logic [63:0] miss_start = '0;
    logic [63:0] miss_cnt = '0;
    logic        fill_v = 1'b0;
    logic [79:0] fill_sid = '0;
    logic [63:0] fill_seq = '0;
    logic [15:0] fill_cnt = '0;
    logic        overflow_o;
    logic        drop_o;
`ifdef MISS_REQ_SCHED_STATS_EN
    logic [31:0] stat_req_o, stat_retry_o, stat_drop_o, stat_ovf_o;
`endif

    int checks = 0;
    int errors = 0;
    int ovf_seen = 0;
    int drop_seen = 0;
    int cyc = 0;

    miss_req_sched_if #(.SEQ_NUM_W(64), .SID_W(80), .ML_W(16)) rq ();

    miss_req_sched #(
        .FIFO_DEPTH (DEPTH),
        .MAX_REQ_CNT(16'hFFFF),
        .TIMEOUT    (TIMEOUT),
        .RETRY_MAX  (RETRY_MAX)
    ) dut (
        .clk                 (clk),
        .nreset              (nreset),
        .miss_seq_num_v_i    (miss_v),
        .miss_seq_num_sid_i  (miss_sid),
        .miss_seq_num_start_i(miss_start),
        .miss_seq_num_cnt_i  (miss_cnt),
        .fill_v_i            (fill_v),
        .fill_sid_i          (fill_sid),
        .fill_seq_num_i      (fill_seq),
        .fill_msg_cnt_i      (fill_cnt),
        .rq                  (rq.master),
        .overflow_o          (overflow_o),
`ifdef MISS_REQ_SCHED_STATS_EN
        .drop_o              (drop_o),
        .stat_req_o          (stat_req_o),
        .stat_retry_o        (stat_retry_o),
        .stat_drop_o         (stat_drop_o),
        .stat_ovf_o          (stat_ovf_o)
`else
        .drop_o              (drop_o)
`endif
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (overflow_o) ovf_seen <= ovf_seen + 1;
        if (drop_o)     drop_seen <= drop_seen + 1;
    end

    initial begin
        #2_000_000;
        $display("FAIL global_timeout sim time limit reached");
        $fatal(1, "timeout");
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic gap(input logic [79:0] sid, input logic [63:0] start, input logic [63:0] cnt);
        miss_v = 1'b1; miss_sid = sid; miss_start = start; miss_cnt = cnt;
        tick();
        miss_v = 1'b0;
    endtask

    task automatic fill(input logic [79:0] sid, input logic [63:0] seq, input logic [15:0] cnt);
        fill_v = 1'b1; fill_sid = sid; fill_seq = seq; fill_cnt = cnt;
        tick();
        fill_v = 1'b0;
    endtask

    // Waits for a request and completes the handshake; returns its fields.
    task automatic get_req(input int budget, output logic [79:0] sid, output logic [63:0] seq,
                           output logic [15:0] cnt, output bit ok, output int at_cyc);
        ok = 1'b0; sid = '0; seq = '0; cnt = '0; at_cyc = 0;
        rq.req_ready_i = 1'b1;
        for (int i = 0; i < budget; i++) begin
            if (rq.req_v_o) begin
                sid = rq.req_sid_o; seq = rq.req_seq_num_o; cnt = rq.req_msg_cnt_o;
                at_cyc = cyc; ok = 1'b1;
                tick();
                break;
            end
            tick();
        end
        rq.req_ready_i = 1'b0;
    endtask

    task automatic count_req_cycles(input int n, output int seen);
        seen = 0;
        for (int i = 0; i < n; i++) begin
            if (rq.req_v_o) seen++;
            tick();
        end
    endtask

    task automatic test_reset();
        rq.req_ready_i = 1'b0;
        nreset = 1'b0;
        repeat (3) tick();
        checks++;
        if ({rq.req_v_o, overflow_o, drop_o} !== 3'b000) begin
            errors++; $display("FAIL reset_flags got %b want 000", {rq.req_v_o, overflow_o, drop_o});
        end
        checks++;
        if ({rq.req_sid_o, rq.req_seq_num_o, rq.req_msg_cnt_o} !== '0) begin
            errors++; $display("FAIL reset_fields got %h/%h/%h want 0", rq.req_sid_o, rq.req_seq_num_o, rq.req_msg_cnt_o);
        end
        nreset = 1'b1;
        tick();
    endtask

    task automatic test_single();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int seen; int d0;
        d0 = drop_seen;
        gap(80'd5, 64'd100, 64'd10);
        checks++;
        if (rq.req_v_o !== 1'b0) begin errors++; $display("FAIL single_lat1 got %b want 0", rq.req_v_o); end
        tick();
        checks++;
        if (rq.req_v_o !== 1'b0) begin errors++; $display("FAIL single_lat2 got %b want 0", rq.req_v_o); end
        tick();
        checks++;
        if (rq.req_v_o !== 1'b1) begin errors++; $display("FAIL single_lat3 got %b want 1", rq.req_v_o); end
        get_req(10, s, q, c, ok, at);
        checks++;
        if (!ok || s !== 80'd5 || q !== 64'd100 || c !== 16'd10) begin
            errors++; $display("FAIL single_req ok=%0d got %0d/%0d/%0d want 5/100/10", ok, s, q, c);
        end
        fill(80'd5, 64'd100, 16'd10);
        count_req_cycles(TIMEOUT + 16, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL single_idle got %0d req cycles want 0", seen); end
        checks++;
        if (drop_seen - d0 !== 0) begin errors++; $display("FAIL single_nodrop got %0d want 0", drop_seen - d0); end
    endtask

    task automatic test_chunking();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int seen;
        logic [63:0] exp_q [3];
        logic [15:0] exp_c [3];
        exp_q[0] = 64'd1000;  exp_c[0] = 16'hFFFF;
        exp_q[1] = 64'd66535; exp_c[1] = 16'hFFFF;
        exp_q[2] = 64'd132070; exp_c[2] = 16'd7;
        gap(80'd7, 64'd1000, 64'h2_0005);
        for (int i = 0; i < 3; i++) begin
            get_req(20, s, q, c, ok, at);
            checks++;
            if (!ok || s !== 80'd7 || q !== exp_q[i] || c !== exp_c[i]) begin
                errors++; $display("FAIL chunk%0d ok=%0d got %0d/%0d/%h want 7/%0d/%h", i, ok, s, q, c, exp_q[i], exp_c[i]);
            end
            fill(80'd7, q, c);
        end
        count_req_cycles(16, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL chunk_end got %0d req cycles want 0", seen); end
    endtask

    task automatic test_partial_fill();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int seen;
        gap(80'd9, 64'd50, 64'd8);
        get_req(20, s, q, c, ok, at);
        checks++;
        if (!ok || s !== 80'd9 || q !== 64'd50 || c !== 16'd8) begin
            errors++; $display("FAIL partial_req1 ok=%0d got %0d/%0d/%0d want 9/50/8", ok, s, q, c);
        end
        fill(80'd8, 64'd50, 16'd8);   // other session: must be ignored
        fill(80'd9, 64'd50, 16'd3);
        get_req(10, s, q, c, ok, at);
        checks++;
        if (!ok || s !== 80'd9 || q !== 64'd53 || c !== 16'd5) begin
            errors++; $display("FAIL partial_req2 ok=%0d got %0d/%0d/%0d want 9/53/5", ok, s, q, c);
        end
        fill(80'd9, 64'd53, 16'd5);
        count_req_cycles(16, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL partial_end got %0d req cycles want 0", seen); end
    endtask

    task automatic test_retry_drop();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int prev_at; int seen; int d0;
        d0 = drop_seen;
        prev_at = 0;
        gap(80'd3, 64'd200, 64'd10);
        for (int i = 0; i <= RETRY_MAX; i++) begin
            get_req(TIMEOUT + 20, s, q, c, ok, at);
            checks++;
            if (!ok || s !== 80'd3 || q !== 64'd200 || c !== 16'd10) begin
                errors++; $display("FAIL retry_req%0d ok=%0d got %0d/%0d/%0d want 3/200/10", i, ok, s, q, c);
            end
            if (i > 0) begin
                checks++;
                if (at - prev_at < TIMEOUT) begin
                    errors++; $display("FAIL retry_gap%0d got %0d cycles want >=%0d", i, at - prev_at, TIMEOUT);
                end
            end
            prev_at = at;
        end
        checks++;
        if (drop_seen - d0 !== 0) begin errors++; $display("FAIL drop_early got %0d want 0", drop_seen - d0); end
        count_req_cycles(TIMEOUT + 20, seen);
        checks++;
        if (drop_seen - d0 !== 1) begin errors++; $display("FAIL drop_pulse got %0d want 1", drop_seen - d0); end
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL drop_idle got %0d req cycles want 0", seen); end
    endtask

    task automatic test_overflow();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int seen; int o0; int bad;
        o0 = ovf_seen;
        rq.req_ready_i = 1'b0;
        for (int i = 0; i < DEPTH + 2; i++) begin
            miss_v = 1'b1; miss_sid = 80'(10 + i); miss_start = 64'(300 + 16 * i); miss_cnt = 64'd2;
            tick();
        end
        miss_v = 1'b0;
        tick(); tick();
        checks++;
        if (ovf_seen - o0 !== 1) begin errors++; $display("FAIL ovf_count got %0d want 1", ovf_seen - o0); end
        bad = 0;
        for (int i = 0; i < 8; i++) begin
            if (rq.req_v_o !== 1'b1 || rq.req_sid_o !== 80'd10 || rq.req_seq_num_o !== 64'd300
                || rq.req_msg_cnt_o !== 16'd2) bad++;
            tick();
        end
        checks++;
        if (bad !== 0) begin errors++; $display("FAIL hold_stable got %0d unstable cycles want 0", bad); end
        for (int i = 0; i < DEPTH + 1; i++) begin
            get_req(20, s, q, c, ok, at);
            checks++;
            if (!ok || s !== 80'(10 + i) || q !== 64'(300 + 16 * i) || c !== 16'd2) begin
                errors++; $display("FAIL drain%0d ok=%0d got %0d/%0d/%0d want %0d/%0d/2", i, ok, s, q, c, 10 + i, 300 + 16 * i);
            end
            fill(s, q, c);
        end
        count_req_cycles(16, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL drain_end got %0d req cycles want 0", seen); end
    endtask

    task automatic test_reset_mid_op();
        logic [79:0] s; logic [63:0] q; logic [15:0] c; bit ok; int at; int seen;
        gap(80'd4, 64'd500, 64'd5);
        get_req(20, s, q, c, ok, at);
        gap(80'd4, 64'd600, 64'd2);
        tick(); tick();
        nreset = 1'b0;
        tick();
        checks++;
        if (rq.req_v_o !== 1'b0 || rq.req_seq_num_o !== 64'd0) begin
            errors++; $display("FAIL midrst_out got v=%b seq=%0d want 0/0", rq.req_v_o, rq.req_seq_num_o);
        end
        nreset = 1'b1;
        count_req_cycles(TIMEOUT + 20, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_empty got %0d req cycles want 0", seen); end
        gap(80'd4, 64'd700, 64'd3);
        get_req(20, s, q, c, ok, at);
        checks++;
        if (!ok || s !== 80'd4 || q !== 64'd700 || c !== 16'd3) begin
            errors++; $display("FAIL midrst_new ok=%0d got %0d/%0d/%0d want 4/700/3", ok, s, q, c);
        end
        fill(80'd4, 64'd700, 16'd3);
        count_req_cycles(16, seen);
        checks++;
        if (seen !== 0) begin errors++; $display("FAIL midrst_end got %0d req cycles want 0", seen); end
    endtask

    initial begin
        rq.req_ready_i = 1'b0;
        test_reset();
        test_single();
        test_chunking();
        test_partial_fill();
        test_retry_drop();
        test_overflow();
        test_reset_mid_op();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
